// File: rtl/duart_pkg.sv
// Shared constants, state encodings and channel-A init ROM for the DUART host sequencer.
package duart_pkg;

  localparam logic [3:0] ADDR_MR      = 4'h0;
  localparam logic [3:0] ADDR_SR_CSR  = 4'h1;
  localparam logic [3:0] ADDR_CR      = 4'h2;
  localparam logic [3:0] ADDR_RHR_THR = 4'h3;
  localparam logic [3:0] ADDR_IMR     = 4'h5;

  localparam int SR_RXRDY = 0;
  localparam int SR_TXRDY = 2;

  localparam int INIT_LEN = 6;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_SR,
    ST_RD_RHR,
    ST_WR_THR
  } ctrl_state_e;

  typedef enum logic [1:0] {
    BC_IDLE,
    BC_SETUP,
    BC_STROBE,
    BC_HOLD
  } bus_phase_e;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } init_entry_t;

  // The baud byte is a top-level parameter, so it is passed in rather than stored here.
  function automatic init_entry_t init_rom(input logic [2:0] idx, input logic [7:0] baud);
    init_entry_t e;
    case (idx)
      3'd0:    e = '{addr: ADDR_CR,     data: 8'h10};
      3'd1:    e = '{addr: ADDR_MR,     data: 8'h13};
      3'd2:    e = '{addr: ADDR_MR,     data: 8'h07};
      3'd3:    e = '{addr: ADDR_SR_CSR, data: baud};
      3'd4:    e = '{addr: ADDR_CR,     data: 8'h05};
      default: e = '{addr: ADDR_IMR,    data: 8'h00};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/duart_bus_cycle.sv
// One DUART register access: SETUP, STROBE_CYCLES of CS low, then HOLD with done.
module duart_bus_cycle
  import duart_pkg::*;
#(
  parameter int STROBE_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [3:0] addr_i,
  input  logic       we_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] din_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic [3:0] a_o,
  output logic       rw_o,
  output logic       cs_n_o,
  output logic [7:0] dout_o
);

  localparam int CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_CYCLES - 1);

  bus_phase_e       phase_q;
  logic [CNT_W-1:0] strb_cnt_q;
  logic [3:0]       a_q;
  logic             rw_q;
  logic             cs_n_q;
  logic [7:0]       dout_q;
  logic [7:0]       rdata_q;
  logic             last_strobe;

  assign last_strobe = (phase_q == BC_STROBE) && (strb_cnt_q == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q    <= BC_IDLE;
      strb_cnt_q <= '0;
      a_q        <= 4'h0;
      rw_q       <= 1'b1;
      cs_n_q     <= 1'b1;
      dout_q     <= 8'h00;
    end else begin
      case (phase_q)
        BC_IDLE: begin
          if (start_i) begin
            phase_q <= BC_SETUP;
            a_q     <= addr_i;
            rw_q    <= ~we_i;
            if (we_i) dout_q <= wdata_i;
          end
        end
        BC_SETUP: begin
          phase_q    <= BC_STROBE;
          cs_n_q     <= 1'b0;
          strb_cnt_q <= '0;
        end
        BC_STROBE: begin
          if (last_strobe) begin
            phase_q <= BC_HOLD;
            cs_n_q  <= 1'b1;
          end else begin
            strb_cnt_q <= strb_cnt_q + CNT_W'(1);
          end
        end
        BC_HOLD: begin
          // Address and write data stay put; only the direction line relaxes to read.
          phase_q <= BC_IDLE;
          rw_q    <= 1'b1;
        end
        default: phase_q <= BC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (last_strobe) rdata_q <= din_i;
  end

  assign done_o  = (phase_q == BC_HOLD);
  assign rdata_o = rdata_q;
  assign a_o     = a_q;
  assign rw_o    = rw_q;
  assign cs_n_o  = cs_n_q;
  assign dout_o  = dout_q;

endmodule

// File: rtl/duart_host_ctrl.sv
// CPU-less host for the MC68681: channel-A init, SRA polling, and TX/RX byte streams.
module duart_host_ctrl
  import duart_pkg::*;
#(
  parameter int         STROBE_CYCLES = 2,
  parameter int         POLL_INTERVAL = 16,
  parameter logic [7:0] BAUD_CSR      = 8'hBB
) (
  input  logic       CLK,
  input  logic       RST,
  output logic [3:0] A,
  output logic       R_W,
  output logic       CS,
  output logic [7:0] DATA_OUT,
  input  logic [7:0] DATA_IN,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       INIT_DONE
);

  localparam int POLL_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_INTERVAL - 1);

  ctrl_state_e       state_q;
  logic [2:0]        init_idx_q;
  logic [POLL_W-1:0] poll_cnt_q;
  logic              issued_q;
  logic              tx_ready_q;
  logic              rx_valid_q;
  logic [7:0]        rx_data_q;
  logic              init_done_q;

  logic              bus_start_d;
  logic [3:0]        bus_addr_d;
  logic              bus_we_d;
  logic [7:0]        bus_wdata_d;
  init_entry_t       rom_entry;

  logic              bus_done;
  logic [7:0]        bus_rdata;

  // Each access state issues exactly one start on its first cycle, which also
  // provides the mandatory idle cycle between consecutive bus accesses.
  always_comb begin
    rom_entry   = init_rom(init_idx_q, BAUD_CSR);
    bus_start_d = 1'b0;
    bus_addr_d  = ADDR_SR_CSR;
    bus_we_d    = 1'b0;
    bus_wdata_d = 8'h00;
    case (state_q)
      ST_INIT: begin
        bus_start_d = ~issued_q;
        bus_addr_d  = rom_entry.addr;
        bus_we_d    = 1'b1;
        bus_wdata_d = rom_entry.data;
      end
      ST_RD_SR: begin
        bus_start_d = ~issued_q;
      end
      ST_RD_RHR: begin
        bus_start_d = ~issued_q;
        bus_addr_d  = ADDR_RHR_THR;
      end
      ST_WR_THR: begin
        bus_start_d = ~issued_q & TX_VALID;
        bus_addr_d  = ADDR_RHR_THR;
        bus_we_d    = 1'b1;
        bus_wdata_d = TX_DATA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_INIT;
      init_idx_q  <= 3'd0;
      poll_cnt_q  <= '0;
      issued_q    <= 1'b0;
      tx_ready_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      init_done_q <= 1'b0;
    end else begin
      tx_ready_q <= 1'b0;
      if (rx_valid_q && RX_READY) rx_valid_q <= 1'b0;
      if (bus_start_d) issued_q <= 1'b1;

      case (state_q)
        ST_INIT: begin
          if (bus_done) begin
            issued_q <= 1'b0;
            if (init_idx_q == 3'(INIT_LEN - 1)) begin
              state_q     <= ST_IDLE;
              init_done_q <= 1'b1;
              poll_cnt_q  <= '0;
            end else begin
              init_idx_q <= init_idx_q + 3'd1;
            end
          end
        end
        ST_IDLE: begin
          if (TX_VALID || (poll_cnt_q == POLL_LAST)) begin
            state_q    <= ST_RD_SR;
            poll_cnt_q <= '0;
          end else begin
            poll_cnt_q <= poll_cnt_q + POLL_W'(1);
          end
        end
        ST_RD_SR: begin
          if (bus_done) begin
            issued_q <= 1'b0;
            // RX wins ties; a held RX byte masks RxRDY so the FIFO keeps the backlog.
            if (bus_rdata[SR_RXRDY] && !rx_valid_q) begin
              state_q <= ST_RD_RHR;
            end else if (bus_rdata[SR_TXRDY] && TX_VALID) begin
              state_q <= ST_WR_THR;
            end else begin
              state_q    <= ST_IDLE;
              poll_cnt_q <= '0;
            end
          end
        end
        ST_RD_RHR: begin
          if (bus_done) begin
            issued_q   <= 1'b0;
            rx_data_q  <= bus_rdata;
            rx_valid_q <= 1'b1;
            state_q    <= ST_RD_SR;
          end
        end
        ST_WR_THR: begin
          if (!issued_q) begin
            if (TX_VALID) begin
              tx_ready_q <= 1'b1;
            end else begin
              state_q    <= ST_IDLE;
              poll_cnt_q <= '0;
            end
          end else if (bus_done) begin
            issued_q   <= 1'b0;
            state_q    <= ST_IDLE;
            poll_cnt_q <= '0;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  duart_bus_cycle #(
    .STROBE_CYCLES(STROBE_CYCLES)
  ) u_bus (
    .clk_i   (CLK),
    .rst_i   (RST),
    .start_i (bus_start_d),
    .addr_i  (bus_addr_d),
    .we_i    (bus_we_d),
    .wdata_i (bus_wdata_d),
    .din_i   (DATA_IN),
    .done_o  (bus_done),
    .rdata_o (bus_rdata),
    .a_o     (A),
    .rw_o    (R_W),
    .cs_n_o  (CS),
    .dout_o  (DATA_OUT)
  );

  assign TX_READY  = tx_ready_q;
  assign RX_VALID  = rx_valid_q;
  assign RX_DATA   = rx_data_q;
  assign INIT_DONE = init_done_q;

endmodule

// File: tb/tb_duart_host_ctrl.sv
// Directed bench for duart_host_ctrl with a tiny DUART register model and a bus access log.
module tb_duart_host_ctrl;

  localparam int STROBE = 2;
  localparam int POLL   = 16;
  localparam int POLL_PERIOD = POLL + STROBE + 3;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] A;
  logic       R_W;
  logic       CS;
  logic [7:0] DATA_OUT;
  logic [7:0] DATA_IN;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY;
  logic       INIT_DONE;

  logic [7:0] sra_val;
  logic [7:0] rhr_val;

  duart_host_ctrl #(
    .STROBE_CYCLES(STROBE),
    .POLL_INTERVAL(POLL),
    .BAUD_CSR     (8'hBB)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .A        (A),
    .R_W      (R_W),
    .CS       (CS),
    .DATA_OUT (DATA_OUT),
    .DATA_IN  (DATA_IN),
    .TX_DATA  (TX_DATA),
    .TX_VALID (TX_VALID),
    .TX_READY (TX_READY),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
    .RX_READY (RX_READY),
    .INIT_DONE(INIT_DONE)
  );

  always #5 CLK = ~CLK;

  assign DATA_IN = (A == 4'h1) ? sra_val : (A == 4'h3) ? rhr_val : 8'h00;

  typedef struct {
    logic [3:0] a;
    logic       rw;
    logic [7:0] d;
    int         len;
    int         start;
    int         hold;
  } acc_t;

  acc_t q[$];
  acc_t acc;
  int   cyc = 0;
  int   low_start = 0;
  int   low_len = 0;
  logic prev_cs = 1'b1;
  logic prev_done = 1'b0;
  int   done_rise_cyc = 0;
  int   txr_cnt = 0;
  int   txr_cyc = 0;

  int total = 0;
  int bad = 0;

  logic [3:0] exp_a [6] = '{4'h2, 4'h0, 4'h0, 4'h1, 4'h2, 4'h5};
  logic [7:0] exp_d [6] = '{8'h10, 8'h13, 8'h07, 8'hBB, 8'h05, 8'h00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor samples 1 time unit after each rising edge.
  always begin
    @(posedge CLK);
    #1;
    cyc++;
    if (TX_READY) begin
      txr_cnt++;
      txr_cyc = cyc;
    end
    if (INIT_DONE && !prev_done) done_rise_cyc = cyc;
    prev_done = INIT_DONE;
    if (!CS) begin
      if (prev_cs) begin
        low_start = cyc;
        low_len = 0;
      end
      low_len++;
    end else if (!prev_cs) begin
      acc.a = A;
      acc.rw = R_W;
      acc.d = DATA_OUT;
      acc.len = low_len;
      acc.start = low_start;
      acc.hold = cyc;
      q.push_back(acc);
    end
    prev_cs = CS;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    int srcnt;
    int starts[$];

    RST = 1'b1; TX_VALID = 1'b0; TX_DATA = 8'h00; RX_READY = 1'b0;
    sra_val = 8'h00; rhr_val = 8'h00;
    repeat (3) @(negedge CLK);
    chk("rst_cs", CS, 1);
    chk("rst_rw", R_W, 1);
    chk("rst_a", A, 0);
    chk("rst_dout", DATA_OUT, 0);
    chk("rst_txr", TX_READY, 0);
    chk("rst_rxv", RX_VALID, 0);
    chk("rst_rxd", RX_DATA, 0);
    chk("rst_initdone", INIT_DONE, 0);

    // Initialisation sequence
    RST = 1'b0;
    q.delete();
    for (int i = 0; i < 200 && !INIT_DONE; i++) @(negedge CLK);
    chk("init_done_seen", INIT_DONE, 1);
    chk("init_cnt", q.size(), 6);
    if (q.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("init_addr", q[i].a, exp_a[i]);
        chk("init_data", q[i].d, exp_d[i]);
        chk("init_rw", q[i].rw, 0);
        chk("init_cs_len", q[i].len, STROBE);
      end
      chk("init_done_lat", done_rise_cyc, q[5].hold + 1);
    end

    // TX path
    q.delete(); txr_cnt = 0;
    sra_val = 8'h04; TX_DATA = 8'h41; TX_VALID = 1'b1;
    for (int i = 0; i < 100 && !TX_READY; i++) @(negedge CLK);
    chk("tx_ready_seen", TX_READY, 1);
    TX_VALID = 1'b0;
    repeat (10) @(negedge CLK);
    sra_val = 8'h00;
    n = q.size();
    chk("tx_acc_min", n >= 2, 1);
    if (n >= 2) begin
      chk("tx_sr_read", {q[n-2].a, q[n-2].rw}, {4'h1, 1'b1});
      chk("tx_thr_addr", q[n-1].a, 3);
      chk("tx_thr_rw", q[n-1].rw, 0);
      chk("tx_thr_data", q[n-1].d, 8'h41);
      chk("tx_ready_at_setup", txr_cyc, q[n-1].start - 1);
    end
    chk("tx_ready_pulses", txr_cnt, 1);

    // RX path with backpressure
    q.delete();
    sra_val = 8'h01; rhr_val = 8'h5A;
    for (int i = 0; i < 100 && !RX_VALID; i++) @(negedge CLK);
    chk("rx_valid_set", RX_VALID, 1);
    chk("rx_data", RX_DATA, 8'h5A);
    repeat (60) @(negedge CLK);
    chk("rx_held", RX_VALID, 1);
    sra_val = 8'h00;
    repeat (10) @(negedge CLK);
    cnt = 0; srcnt = 0;
    foreach (q[i]) begin
      if (q[i].a == 4'h3 && q[i].rw) cnt++;
      if (q[i].a == 4'h1 && q[i].rw) srcnt++;
    end
    chk("rx_rhr_reads", cnt, 1);
    chk("rx_polls_while_held", srcnt >= 3, 1);
    RX_READY = 1'b1;
    @(negedge CLK);
    chk("rx_valid_clr", RX_VALID, 0);
    RX_READY = 1'b0;

    // RX and TX ready together: RX first, re-poll, then TX
    q.delete(); txr_cnt = 0;
    sra_val = 8'h05; rhr_val = 8'h33; TX_DATA = 8'h77; TX_VALID = 1'b1;
    for (int i = 0; i < 200 && !TX_READY; i++) @(negedge CLK);
    chk("prio_tx_ready_seen", TX_READY, 1);
    TX_VALID = 1'b0; sra_val = 8'h00;
    repeat (10) @(negedge CLK);
    n = q.size();
    chk("prio_acc_min", n >= 3, 1);
    if (n >= 3) begin
      chk("prio_rhr_first", {q[n-3].a, q[n-3].rw}, {4'h3, 1'b1});
      chk("prio_repoll", {q[n-2].a, q[n-2].rw}, {4'h1, 1'b1});
      chk("prio_thr", {q[n-1].a, q[n-1].rw, q[n-1].d}, {4'h3, 1'b0, 8'h77});
    end
    chk("prio_rx_valid", RX_VALID, 1);
    chk("prio_rx_data", RX_DATA, 8'h33);
    RX_READY = 1'b1;
    @(negedge CLK);
    RX_READY = 1'b0;

    // Idle polling cadence
    repeat (30) @(negedge CLK);
    q.delete();
    repeat (90) @(negedge CLK);
    foreach (q[i]) if (q[i].a == 4'h1 && q[i].rw) starts.push_back(q[i].start);
    chk("poll_count", starts.size() >= 3, 1);
    for (int i = 1; i < starts.size(); i++)
      chk("poll_gap", starts[i] - starts[i-1], POLL_PERIOD);

    // Reset during a THRA write strobe
    sra_val = 8'h04; TX_DATA = 8'h55; TX_VALID = 1'b1;
    for (int i = 0; i < 100 && !(!CS && A == 4'h3 && !R_W); i++) @(negedge CLK);
    chk("rst_thr_strobe_seen", (!CS && A == 4'h3 && !R_W), 1);
    RST = 1'b1; TX_VALID = 1'b0;
    @(negedge CLK);
    chk("midrst_cs", CS, 1);
    chk("midrst_rw", R_W, 1);
    chk("midrst_txr", TX_READY, 0);
    chk("midrst_initdone", INIT_DONE, 0);
    @(negedge CLK);
    RST = 1'b0; sra_val = 8'h00;
    q.delete();
    for (int i = 0; i < 200 && !INIT_DONE; i++) @(negedge CLK);
    chk("reinit_done", INIT_DONE, 1);
    chk("reinit_cnt", q.size(), 6);
    if (q.size() >= 6) begin
      chk("reinit_first", {q[0].a, q[0].rw, q[0].d}, {4'h2, 1'b0, 8'h10});
      chk("reinit_last", {q[5].a, q[5].rw, q[5].d}, {4'h5, 1'b0, 8'h00});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
